// File: rtl/race_gfx_pkg.sv
// Shared constants and payload types for the split-screen race renderer.
package race_gfx_pkg;

  localparam logic [11:0] TRANSPARENT     = 12'h000;
  localparam logic [11:0] BLANK_COLOR     = 12'h000;
  localparam logic [11:0] OUT_BOUND_COLOR = 12'h6B4;
  localparam logic [11:0] SEPARATOR_COLOR = 12'hFFF;
  localparam logic [11:0] HUD_COLOR       = 12'h444;

  localparam int unsigned CAR_SIZE   = 75;
  localparam int unsigned CAR_HALF   = 37;
  localparam int unsigned DEF_MAP_W  = 320;
  localparam int unsigned DEF_MAP_H  = 240;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned PLAY_H     = 360;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned CAR_W      = 7;

  // Per-pixel result of the address generator.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CAR_W-1:0]  car_px;
    logic [CAR_W-1:0]  car_py;
    logic              in_car;
    logic              oob;
  } addr_gen_t;

  // Flags carried from stage 1 to the colour mux.
  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic sep;
    logic hud;
    logic in_car;
    logic oob;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_RST = '{valid: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                       sep: 1'b0, hud: 1'b0, in_car: 1'b0, oob: 1'b0};

endpackage

// File: rtl/viewport_addr_gen.sv
// Combinational view select, map texel address and car sprite box math.
module viewport_addr_gen
  import race_gfx_pkg::*;
#(
  parameter int unsigned NUM_VIEWS  = 2,
  parameter int unsigned MAP_W      = DEF_MAP_W,
  parameter int unsigned MAP_H      = DEF_MAP_H,
  parameter int unsigned ZOOM_SHIFT = 2
) (
  input  logic [9:0]              i_h_cnt,
  input  logic [9:0]              i_v_cnt,
  input  logic [NUM_VIEWS*10-1:0] i_pos_x,
  input  logic [NUM_VIEWS*10-1:0] i_pos_y,
  output addr_gen_t               o_gen_c
);

  localparam int unsigned VIEW_W   = (NUM_VIEWS == 1) ? SCREEN_W : SCREEN_W / 2;
  localparam int unsigned VIEW_H   = (NUM_VIEWS == 4) ? PLAY_H / 2 : PLAY_H;
  localparam int unsigned HALF_W_Z = (VIEW_W / 2) >> ZOOM_SHIFT;
  localparam int unsigned HALF_H_Z = (VIEW_H / 2) >> ZOOM_SHIFT;
  localparam int unsigned CAR_X0   = VIEW_W / 2 - CAR_HALF;
  localparam int unsigned CAR_X1   = VIEW_W / 2 + CAR_HALF;
  localparam int unsigned CAR_Y0   = VIEW_H / 2 - CAR_HALF;
  localparam int unsigned CAR_Y1   = VIEW_H / 2 + CAR_HALF;

  logic       w_in_view;
  logic       w_right;
  logic       w_lower;
  logic [1:0] w_view;
  logic [9:0] w_rx;
  logic [9:0] w_ry;
  logic [9:0] w_px;
  logic [9:0] w_py;
  logic [9:0] w_gx;
  logic [9:0] w_gy;
  logic       w_oob;
  logic       w_in_car;

  // Which view the beam is in and its origin-relative coordinates.
  assign w_in_view = (i_h_cnt < 10'(SCREEN_W)) && (i_v_cnt < 10'(PLAY_H));
  assign w_right   = (NUM_VIEWS > 1) && (i_h_cnt >= 10'(VIEW_W));
  assign w_lower   = (NUM_VIEWS == 4) && (i_v_cnt >= 10'(VIEW_H));
  assign w_view    = {w_lower, w_right};
  assign w_rx      = i_h_cnt - (w_right ? 10'(VIEW_W) : 10'd0);
  assign w_ry      = i_v_cnt - (w_lower ? 10'(VIEW_H) : 10'd0);

  // Select the owning player's shadowed position.
  always_comb begin
    w_px = '0;
    w_py = '0;
    for (int k = 0; k < NUM_VIEWS; k++) begin
      if (w_view == 2'(k)) begin
        w_px = i_pos_x[10*k +: 10];
        w_py = i_pos_y[10*k +: 10];
      end
    end
  end

  // Camera-centred map coordinates, wrapping mod 1024 so negatives land out of bounds.
  assign w_gx  = (w_rx >> ZOOM_SHIFT) + w_px - 10'(HALF_W_Z);
  assign w_gy  = (w_ry >> ZOOM_SHIFT) + w_py - 10'(HALF_H_Z);
  assign w_oob = (32'(w_gx) >= MAP_W) || (32'(w_gy) >= MAP_H);

  assign w_in_car = w_in_view
                 && (w_rx >= 10'(CAR_X0)) && (w_rx <= 10'(CAR_X1))
                 && (w_ry >= 10'(CAR_Y0)) && (w_ry <= 10'(CAR_Y1));

  // Pack results; address and sprite coordinates are zeroed where not applicable.
  always_comb begin
    o_gen_c        = '0;
    o_gen_c.oob    = w_oob;
    o_gen_c.in_car = w_in_car;
    if (w_in_view && !w_oob) begin
      o_gen_c.addr = ADDR_W'(32'(w_gy) * MAP_W + 32'(w_gx));
    end
    if (w_in_car) begin
      o_gen_c.car_px = CAR_W'(w_rx - 10'(CAR_X0));
      o_gen_c.car_py = CAR_W'(w_ry - 10'(CAR_Y0));
    end
  end

endmodule

// File: rtl/viewport_compositor.sv
// Two-stage split-screen compositor: map/car address generation, then colour mux.
module viewport_compositor
  import race_gfx_pkg::*;
#(
  parameter int unsigned NUM_VIEWS  = 2,
  parameter int unsigned MAP_W      = DEF_MAP_W,
  parameter int unsigned MAP_H      = DEF_MAP_H,
  parameter int unsigned ZOOM_SHIFT = 2,
  parameter int unsigned HUD_TOP    = 360
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_en,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  input  logic                    valid_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic [NUM_VIEWS*10-1:0] player_x,
  input  logic [NUM_VIEWS*10-1:0] player_y,
  output logic [16:0]             map_addr,
  input  logic [11:0]             map_rgb,
  output logic [6:0]              car_px,
  output logic [6:0]              car_py,
  input  logic [11:0]             car_rgb,
  output logic [11:0]             rgb_out,
  output logic                    valid_out,
  output logic                    hsync_out,
  output logic                    vsync_out
);

  generate
    if (!(NUM_VIEWS == 1 || NUM_VIEWS == 2 || NUM_VIEWS == 4)) begin : g_bad_views
      $error("viewport_compositor: NUM_VIEWS must be 1, 2 or 4");
    end
  endgenerate

  logic [NUM_VIEWS*10-1:0] r_sx;
  logic [NUM_VIEWS*10-1:0] r_sy;
  addr_gen_t               w_gen;
  logic                    w_sep;
  logic                    w_hud;
  logic [16:0]             r_map_addr;
  logic [6:0]              r_car_px;
  logic [6:0]              r_car_py;
  pix_flags_t              r_flags;
  logic [11:0]             w_rgb_nxt;
  logic [11:0]             r_rgb;
  logic                    r_valid;
  logic                    r_hsync;
  logic                    r_vsync;

  // Shadow positions update only at the top-left pixel so a frame is drawn from one snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (pix_en && h_cnt == 10'd0 && v_cnt == 10'd0) begin
      r_sx <= player_x;
      r_sy <= player_y;
    end
  end

  viewport_addr_gen #(
    .NUM_VIEWS (NUM_VIEWS),
    .MAP_W     (MAP_W),
    .MAP_H     (MAP_H),
    .ZOOM_SHIFT(ZOOM_SHIFT)
  ) u_addr_gen (
    .i_h_cnt(h_cnt),
    .i_v_cnt(v_cnt),
    .i_pos_x(r_sx),
    .i_pos_y(r_sy),
    .o_gen_c(w_gen)
  );

  assign w_sep = ((NUM_VIEWS > 1) && (h_cnt == 10'd319 || h_cnt == 10'd320))
              || ((NUM_VIEWS == 4) && (v_cnt == 10'd179 || v_cnt == 10'd180))
              || (v_cnt == 10'(HUD_TOP - 1)) || (v_cnt == 10'(HUD_TOP));
  assign w_hud = (v_cnt >= 10'(HUD_TOP));

  // Stage 1: memory addresses to the texel ROMs plus the flags the colour mux needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_map_addr <= '0;
      r_car_px   <= '0;
      r_car_py   <= '0;
      r_flags    <= FLAGS_RST;
    end else if (pix_en) begin
      r_map_addr     <= w_gen.addr;
      r_car_px       <= w_gen.car_px;
      r_car_py       <= w_gen.car_py;
      r_flags.valid  <= valid_in;
      r_flags.hsync  <= hsync_in;
      r_flags.vsync  <= vsync_in;
      r_flags.sep    <= w_sep;
      r_flags.hud    <= w_hud;
      r_flags.in_car <= w_gen.in_car;
      r_flags.oob    <= w_gen.oob;
    end
  end

  // Colour priority: blanking, separators, HUD, opaque car texel, off-map fill, map.
  always_comb begin
    w_rgb_nxt = map_rgb;
    if (!r_flags.valid) begin
      w_rgb_nxt = BLANK_COLOR;
    end else if (r_flags.sep) begin
      w_rgb_nxt = SEPARATOR_COLOR;
    end else if (r_flags.hud) begin
      w_rgb_nxt = HUD_COLOR;
    end else if (r_flags.in_car && car_rgb != TRANSPARENT) begin
      w_rgb_nxt = car_rgb;
    end else if (r_flags.oob) begin
      w_rgb_nxt = OUT_BOUND_COLOR;
    end
  end

  // Stage 2: final pixel and timing aligned with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb   <= '0;
      r_valid <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (pix_en) begin
      r_rgb   <= w_rgb_nxt;
      r_valid <= r_flags.valid;
      r_hsync <= r_flags.hsync;
      r_vsync <= r_flags.vsync;
    end
  end

  assign map_addr  = r_map_addr;
  assign car_px    = r_car_px;
  assign car_py    = r_car_py;
  assign rgb_out   = r_rgb;
  assign valid_out = r_valid;
  assign hsync_out = r_hsync;
  assign vsync_out = r_vsync;

endmodule
